boot_rom_arb: RTL and testbench

Multi-port, pipelined front-end for the boot ROM macro wrapper. Arbitrates NUM_PORTS requesters (core instruction fetch, debug unit, DMA) onto one synchronous single-port ROM.
Generalises data width and alignment, adds an optional output register stage, and returns an error response for misaligned or out-of-range accesses. Sits between the SoC peripheral interconnect and the technology-specific ROM instance.

---
 rtl/boot_rom_arb_pkg.sv | 23 ++
 rtl/boot_rom_arb_if.sv | 18 +
 rtl/boot_rom_arb_rr_arbiter.sv | 31 +++
 rtl/boot_rom_arb.sv | 87 ++++++++
 tb/tb_boot_rom_arb.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/boot_rom_arb_pkg.sv
// boot_rom_pkg: shared widths, pipeline tag and access-check helper for boot_rom_arb
// Provides default BYTE_OFS_W/WADDR_W for a 32-bit ROM, width helpers for other
// DATA_WIDTH choices, the S1 pipeline tag type and the misalign/range check.
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 16
`endif
package boot_rom_pkg;
  localparam int PORT_ID_W      = 3;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int BYTE_OFS_W     = $clog2(DEF_DATA_WIDTH / 8);
  localparam int WADDR_W        = `ROM_ADDR_WIDTH - BYTE_OFS_W;
  typedef struct packed {
    logic [PORT_ID_W-1:0] id;
    logic                 err;
    logic                 vld;
  } tag_t;
  function automatic int byte_ofs_w(input int dw);
    return $clog2(dw / 8);
  endfunction
  function automatic logic bad_access(input logic [63:0] addr, input int ofs, input int depth);
    return (|(addr & ((64'd1 << ofs) - 64'd1))) || ((addr >> ofs) >= 64'(depth));
  endfunction
endpackage

// File: rtl/boot_rom_arb_if.sv
// boot_rom_arb_if: requester-side bus of boot_rom_arb, all ports packed per requester
// req_i/addr_i  : requester -> arbiter, addr held while req_i=1 and gnt_o=0
// gnt_o         : arbiter -> requester, combinational one-hot grant
// rvalid_o/rdata_o/err_o : arbiter -> requester, in-order read responses
interface boot_rom_arb_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = `ROM_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]                 req_i;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_i;
  logic [NUM_PORTS-1:0]                 gnt_o;
  logic [NUM_PORTS-1:0]                 rvalid_o;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_o;
  logic [NUM_PORTS-1:0]                 err_o;
  modport master (output req_i, addr_i, input gnt_o, rvalid_o, rdata_o, err_o);
  modport slave  (input req_i, addr_i, output gnt_o, rvalid_o, rdata_o, err_o);
endinterface

// File: rtl/boot_rom_arb_rr_arbiter.sv
// rr_arbiter: round-robin grant among NUM_PORTS requesters
// i_en  : allow granting this cycle
// i_req : per-port request; o_gnt : one-hot grant; o_id : index of granted port
module rr_arbiter #(
  parameter  int NUM_PORTS = 2,
  localparam int IDW       = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic [NUM_PORTS-1:0] i_req,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [IDW-1:0]       o_id
);
  logic [IDW-1:0] r_ptr;
  // r_ptr is the highest-priority port; scanning downwards lets the port
  // nearest r_ptr overwrite any farther candidate.
  always_comb begin
    o_gnt = '0;
    o_id  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (i_en && i_req[(int'(r_ptr) + i) % NUM_PORTS]) begin
        o_gnt = '0;
        o_gnt[(int'(r_ptr) + i) % NUM_PORTS] = 1'b1;
        o_id = IDW'((int'(r_ptr) + i) % NUM_PORTS);
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= '0;
    else if (|o_gnt) r_ptr <= (int'(o_id) == NUM_PORTS - 1) ? '0 : o_id + 1'b1;
endmodule

// File: rtl/boot_rom_arb.sv
// boot_rom_arb: round-robin, pipelined multi-port read front-end for a single-port boot ROM
// clk/rst_n   : clock, asynchronous active-low reset
// bus         : requester bus (req/addr/gnt/rvalid/rdata/err per port)
// rom_en_o    : ROM enable for accepted, well-formed accesses
// rom_addr_o  : ROM word address, held when no access is issued
// rom_rdata_i : ROM data, valid the cycle after rom_en_o
module boot_rom_arb
  import boot_rom_pkg::*;
#(
  parameter  int NUM_PORTS  = 2,
  parameter  int ADDR_WIDTH = `ROM_ADDR_WIDTH,
  parameter  int DATA_WIDTH = 32,
  parameter  int ROM_DEPTH  = 1024,
  parameter  int OUTPUT_REG = 1,
  localparam int BOW        = byte_ofs_w(DATA_WIDTH),
  localparam int WAW        = ADDR_WIDTH - BOW,
  localparam int IDW        = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  boot_rom_arb_if.slave         bus,
  output logic                  rom_en_o,
  output logic [WAW-1:0]        rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_rdata_i
);
  logic [NUM_PORTS-1:0]  w_gnt;
  logic [NUM_PORTS-1:0]  w_hit;
  logic [IDW-1:0]        w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_any;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_s1_data;
  logic [WAW-1:0]        r_rom_addr;
  tag_t                  r_s1;
  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (1'b1),
    .i_req (bus.req_i),
    .o_gnt (w_gnt),
    .o_id  (w_id)
  );
  assign w_addr      = bus.addr_i[w_id];
  assign w_any       = |w_gnt;
  assign w_err       = w_any && bad_access(64'(w_addr), BOW, ROM_DEPTH);
  assign bus.gnt_o   = w_gnt;
  assign rom_en_o    = w_any && !w_err;
  // Error or idle cycles leave the ROM address untouched to avoid needless toggling.
  assign rom_addr_o  = rom_en_o ? w_addr[ADDR_WIDTH-1:BOW] : r_rom_addr;
  assign w_s1_data   = r_s1.err ? '0 : rom_rdata_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rom_addr <= '0;
      r_s1       <= '0;
    end else begin
      r_rom_addr <= rom_addr_o;
      r_s1       <= '{id: PORT_ID_W'(w_id), err: w_err, vld: w_any};
    end
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_hit
    assign w_hit[g] = r_s1.vld && (r_s1.id == PORT_ID_W'(g));
  end
  if (OUTPUT_REG != 0) begin : g_oreg
    logic [NUM_PORTS-1:0]                 r_rvalid;
    logic [NUM_PORTS-1:0]                 r_err;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] r_rdata;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_rvalid <= '0;
        r_err    <= '0;
        r_rdata  <= '0;
      end else begin
        r_rvalid <= w_hit;
        r_err    <= w_hit & {NUM_PORTS{r_s1.err}};
        for (int k = 0; k < NUM_PORTS; k++)
          if (w_hit[k]) r_rdata[k] <= w_s1_data;
      end
    assign bus.rvalid_o = r_rvalid;
    assign bus.err_o    = r_err;
    assign bus.rdata_o  = r_rdata;
  end else begin : g_comb
    assign bus.rvalid_o = w_hit;
    assign bus.err_o    = w_hit & {NUM_PORTS{r_s1.err}};
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_data
      assign bus.rdata_o[g] = w_hit[g] ? w_s1_data : '0;
    end
  end
endmodule

// File: tb/tb_boot_rom_arb.sv
// tb_boot_rom_arb: scoreboard bench for a 2-port/32b/registered and a 1-port/64b/unregistered instance
module tb_boot_rom_arb;
  typedef struct {
    int          port;
    logic [63:0] data;
    logic        err;
    int          due;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        e_a;
  exp_t        e_b;
  logic        rom_en_a, rom_en_b;
  logic [13:0] rom_addr_a;
  logic [12:0] rom_addr_b;
  logic [31:0] rom_rd_a = '0;
  logic [63:0] rom_rd_b = '0;
  boot_rom_arb_if #(.NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(32)) bus_a ();
  boot_rom_arb_if #(.NUM_PORTS(1), .ADDR_WIDTH(16), .DATA_WIDTH(64)) bus_b ();
  boot_rom_arb #(.NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(32), .ROM_DEPTH(1024), .OUTPUT_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a),
    .rom_en_o(rom_en_a), .rom_addr_o(rom_addr_a), .rom_rdata_i(rom_rd_a)
  );
  boot_rom_arb #(.NUM_PORTS(1), .ADDR_WIDTH(16), .DATA_WIDTH(64), .ROM_DEPTH(1024), .OUTPUT_REG(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b),
    .rom_en_o(rom_en_b), .rom_addr_o(rom_addr_b), .rom_rdata_i(rom_rd_b)
  );
  function automatic logic [31:0] rom_a(input logic [13:0] w);
    return (w == 14'd4) ? 32'hDEADBEEF : (32'h5A00_0000 | 32'(w));
  endfunction
  function automatic logic [63:0] rom_b(input logic [12:0] w);
    return 64'hC0DE_0000_0000_0000 | 64'(w);
  endfunction
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (rom_en_a) rom_rd_a <= rom_a(rom_addr_a);
    if (rom_en_b) rom_rd_b <= rom_b(rom_addr_b);
  end
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cyc %0d)", n, act, exp, cyc);
    end
  endtask
  // Scoreboard monitors: every response pops the oldest expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++)
      if (bus_a.rvalid_o[k]) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL a_resp port %0d rvalid with nothing expected (cyc %0d)", k, cyc);
        end else begin
          e_a = qa.pop_front();
          if (e_a.port != k || 64'(bus_a.rdata_o[k]) !== e_a.data || bus_a.err_o[k] !== e_a.err || e_a.due != cyc) begin
            errors++;
            $display("FAIL a_resp got port %0d data %h err %b cyc %0d expected port %0d data %h err %b cyc %0d",
                     k, bus_a.rdata_o[k], bus_a.err_o[k], cyc, e_a.port, e_a.data, e_a.err, e_a.due);
          end
        end
      end
  end
  always @(negedge clk) begin
    if (bus_b.rvalid_o[0]) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_resp rvalid with nothing expected (cyc %0d)", cyc);
      end else begin
        e_b = qb.pop_front();
        if (64'(bus_b.rdata_o[0]) !== e_b.data || bus_b.err_o[0] !== e_b.err || e_b.due != cyc) begin
          errors++;
          $display("FAIL b_resp got data %h err %b cyc %0d expected data %h err %b cyc %0d",
                   bus_b.rdata_o[0], bus_b.err_o[0], cyc, e_b.data, e_b.err, e_b.due);
        end
      end
    end else if (rst_n) begin
      chk("b_idle_rdata_err", {bus_b.rdata_o[0][62:0], bus_b.err_o[0]}, 64'd0);
    end
  end
  task automatic step_a(input logic [1:0] req, input logic [15:0] a0, input logic [15:0] a1,
                        input logic [1:0] eg, input logic ee, input logic [13:0] ea,
                        input logic eerr, input bit push);
    @(posedge clk);
    #1;
    bus_a.req_i     = req;
    bus_a.addr_i[0] = a0;
    bus_a.addr_i[1] = a1;
    @(negedge clk);
    chk("a_gnt", 64'(bus_a.gnt_o), 64'(eg));
    chk("a_rom_en", 64'(rom_en_a), 64'(ee));
    chk("a_rom_addr", 64'(rom_addr_a), 64'(ea));
    if (push && eg != 2'b00)
      qa.push_back('{eg[1] ? 1 : 0, eerr ? 64'd0 : 64'(rom_a(ea)), eerr, cyc + 2});
  endtask
  task automatic step_b(input logic req, input logic [15:0] a, input logic eg, input logic ee,
                        input logic [12:0] ea, input logic eerr);
    @(posedge clk);
    #1;
    bus_b.req_i     = req;
    bus_b.addr_i[0] = a;
    @(negedge clk);
    chk("b_gnt", 64'(bus_b.gnt_o), 64'(eg));
    chk("b_rom_en", 64'(rom_en_b), 64'(ee));
    chk("b_rom_addr", 64'(rom_addr_b), 64'(ea));
    if (eg) qb.push_back('{0, eerr ? 64'd0 : rom_b(ea), eerr, cyc + 1});
  endtask
  initial begin
    bus_a.req_i  = '0;
    bus_a.addr_i = '0;
    bus_b.req_i  = '0;
    bus_b.addr_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_gnt", 64'(bus_a.gnt_o), 64'd0);
    chk("rst_a_rvalid", 64'(bus_a.rvalid_o), 64'd0);
    chk("rst_a_err", 64'(bus_a.err_o), 64'd0);
    chk("rst_a_rdata", 64'(bus_a.rdata_o), 64'd0);
    chk("rst_a_rom_en", 64'(rom_en_a), 64'd0);
    chk("rst_b_rvalid", 64'(bus_b.rvalid_o), 64'd0);
    chk("rst_b_rdata", 64'(bus_b.rdata_o), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step_a(2'b00, 16'h0, 16'h0, 2'b00, 1'b0, 14'h0, 1'b0, 1'b1);
    // both ports hammering: grants alternate starting with port 0
    step_a(2'b11, 16'h0, 16'h4, 2'b01, 1'b1, 14'h0, 1'b0, 1'b1);
    step_a(2'b11, 16'h0, 16'h4, 2'b10, 1'b1, 14'h1, 1'b0, 1'b1);
    step_a(2'b11, 16'h0, 16'h4, 2'b01, 1'b1, 14'h0, 1'b0, 1'b1);
    step_a(2'b11, 16'h0, 16'h4, 2'b10, 1'b1, 14'h1, 1'b0, 1'b1);
    // single read of word 4
    step_a(2'b01, 16'h10, 16'h0, 2'b01, 1'b1, 14'h4, 1'b0, 1'b1);
    step_a(2'b00, 16'h0, 16'h0, 2'b00, 1'b0, 14'h4, 1'b0, 1'b1);
    // misaligned, out of range, last word
    step_a(2'b10, 16'h0, 16'h2, 2'b10, 1'b0, 14'h4, 1'b1, 1'b1);
    step_a(2'b01, 16'h1000, 16'h0, 2'b01, 1'b0, 14'h4, 1'b1, 1'b1);
    step_a(2'b10, 16'h0, 16'hFFC, 2'b10, 1'b1, 14'h3FF, 1'b0, 1'b1);
    // contention after port 1 win: port 0 first, waiting port 1 next
    step_a(2'b11, 16'h8, 16'hFFC, 2'b01, 1'b1, 14'h2, 1'b0, 1'b1);
    step_a(2'b10, 16'h8, 16'hFFC, 2'b10, 1'b1, 14'h3FF, 1'b0, 1'b1);
    repeat (4) step_a(2'b00, 16'h0, 16'h0, 2'b00, 1'b0, 14'h3FF, 1'b0, 1'b1);
    chk("a_hold_rdata0", 64'(bus_a.rdata_o[0]), 64'h5A00_0002);
    chk("a_hold_rdata1", 64'(bus_a.rdata_o[1]), 64'h5A00_03FF);
    // reset one cycle after a grant drops the in-flight read
    step_a(2'b11, 16'h10, 16'h4, 2'b01, 1'b1, 14'h4, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus_a.req_i = 2'b00;
    @(negedge clk);
    chk("mid_rst_rvalid", 64'(bus_a.rvalid_o), 64'd0);
    chk("mid_rst_rdata", 64'(bus_a.rdata_o), 64'd0);
    chk("mid_rst_err", 64'(bus_a.err_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step_a(2'b00, 16'h0, 16'h0, 2'b00, 1'b0, 14'h0, 1'b0, 1'b1);
    step_a(2'b11, 16'h0, 16'h4, 2'b01, 1'b1, 14'h0, 1'b0, 1'b1);
    step_a(2'b10, 16'h0, 16'h4, 2'b10, 1'b1, 14'h1, 1'b0, 1'b1);
    step_a(2'b00, 16'h0, 16'h0, 2'b00, 1'b0, 14'h1, 1'b0, 1'b1);
    // 64-bit, single port, unregistered response path
    step_b(1'b1, 16'h18, 1'b1, 1'b1, 13'h3, 1'b0);
    step_b(1'b1, 16'h1C, 1'b1, 1'b0, 13'h3, 1'b1);
    step_b(1'b1, 16'h2000, 1'b1, 1'b0, 13'h3, 1'b1);
    step_b(1'b1, 16'h1FF8, 1'b1, 1'b1, 13'h3FF, 1'b0);
    step_b(1'b0, 16'h0, 1'b0, 1'b0, 13'h3FF, 1'b0);
    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    chk("a_drain", 64'(qa.size()), 64'd0);
    chk("b_drain", 64'(qb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
